fir_mac_sequencer: RTL
======================

Name: fir_mac_sequencer

Overview:
Sequencing controller for the FIR filter datapath. It generates the audio sample strobe from the system clock, or takes one from outside. On each strobe it writes the new sample into an external circular delay-line RAM. It then steps through NUM_TAPS multiply-accumulates against an external coefficient RAM, and emits one rounded, saturated output sample with a one-cycle valid pulse.

Parameters:
CLK_HZ, 12_000_000, system clock frequency
SAMPLE_HZ, 48_000, audio sample rate; CLK_DIV = CLK_HZ/SAMPLE_HZ (250 by default)
NUM_TAPS, 32, filter length; power of two, >= 2
DATA_W, 16, signed sample width
COEF_W, 16, signed coefficient width, Q1.(COEF_W-1)
ACC_W, 40, signed accumulator width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  run enable; low = no new sample started
sample_tick  in  1  external strobe, used only with FIR_EXT_TICK_EN
sample_in  in  DATA_W  signed input sample
samp_wr_en  out  1  delay-line RAM write enable
samp_wr_addr  out  $clog2(NUM_TAPS)  delay-line write address
samp_wr_data  out  DATA_W  delay-line write data
samp_rd_addr  out  $clog2(NUM_TAPS)  delay-line read address
samp_rd_data  in  DATA_W  delay-line read data, 1-cycle latency
coef_rd_addr  out  $clog2(NUM_TAPS)  coefficient read address
coef_rd_data  in  COEF_W  coefficient read data, 1-cycle latency
y_out  out  DATA_W  filtered output sample
y_valid  out  1  one-cycle pulse when y_out updates
busy  out  1  high in any state other than IDLE
overrun  out  1  sticky: a tick arrived while busy

Behaviour:
- Reset (rst low, asynchronous):
  - all outputs 0; state IDLE; tick counter 0; write pointer wptr 0; accumulator 0.
  - Applies immediately, including mid-computation. An in-flight sample is discarded and no y_valid is produced for it.
- Internal tick:
  - Counter runs 0..CLK_DIV-1 while en=1 and holds while en=0.
  - Tick is high for one cycle when the counter equals CLK_DIV-1, so the period is exactly CLK_DIV cycles.
  - First tick occurs on cycle CLK_DIV-1 after reset release.
- States: IDLE, WRITE, ISSUE, DRAIN, DONE.
- IDLE: on tick with en=1, capture sample_in, go to WRITE.
- WRITE (1 cycle): samp_wr_en=1, samp_wr_addr=wptr, samp_wr_data=captured sample. Clear the accumulator, set k=0.
- ISSUE (NUM_TAPS cycles):
  - samp_rd_addr=(wptr-k) mod NUM_TAPS; coef_rd_addr=k.
  - From the second ISSUE cycle on, acc += samp_rd_data*coef_rd_data (full-precision signed product, sign-extended to ACC_W).
  - After k=NUM_TAPS-1, go to DRAIN.
- DRAIN (1 cycle): accumulate the final product.
- DONE (1 cycle):
  - y_out = saturate(acc >>> (COEF_W-1)) to the DATA_W signed range. The shift is arithmetic and truncates toward minus infinity.
  - y_valid=1 for this cycle only; wptr = wptr+1 mod NUM_TAPS; return to IDLE.
- Latency: if the tick is high in cycle c0, y_valid is high in cycle c0+NUM_TAPS+3 (c0+35 by default).
- Read/write addresses hold their last values outside their active states.
- Overrun: a tick while busy=1 is ignored, and overrun is set until reset. The dropped sample is not written and wptr is unchanged. The running computation completes normally.
- en falling mid-computation: the current sample completes; no new sample starts.
- Tick and DONE in the same cycle: the tick counts as overrun (busy is still 1).
- Requirement on integrators: NUM_TAPS+4 <= CLK_DIV; violation shows up only as overrun.

Optional Feature:
FIR_EXT_TICK_EN
- Defined: the internal divider is removed and sample_tick (gated by en) is the strobe; all other behaviour is unchanged.
- Undefined: sample_tick is ignored and the internal CLK_DIV tick is used.

Test Plan:
1. Impulse response:
   - Stimulus: all coefficients 16384 (0.5); sample_in 1000 for one tick, then 0.
   - Required: y_out=500 for 32 consecutive outputs, then 0; each y_valid exactly 35 cycles after its tick.
2. Tick period, default parameters, en=1 from reset:
   - Required: first WRITE on cycle 250 after reset release; samp_wr_en pulses spaced exactly 250 cycles; en=0 for 100 cycles delays the next tick by 100.
3. Saturation:
   - Stimulus: all coefficients 32767; sample_in held at 32767.
   - Required: y_out clamps to 32767.
   - Then hold -32768; required: y_out clamps to -32768. No wrap at either rail.
4. Overrun (FIR_EXT_TICK_EN):
   - Stimulus: two ticks 10 cycles apart.
   - Required: one y_valid only; overrun=1 and stays 1; wptr advanced by 1.
5. Reset mid-ISSUE:
   - Stimulus: rst low at ISSUE k=12.
   - Required: outputs 0 the same cycle; no y_valid for that sample; after release the next sample writes address 0 and its result matches a fresh filter.
6. Wrap-around:
   - Stimulus: 40 ramp samples 1..40 with coefficient k = k+1 (Q15 raw).
   - Required: write addresses wrap 31→0; every y_out matches the reference model bit-exactly.

Source files
------------

// File: rtl/fir_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer_if
// Memory-side bus between the FIR MAC sequencer and its two external RAMs.
// The delay-line RAM has one write port and one read port. The coefficient
// RAM has one read port. Both read ports have a 1-cycle latency.
//   master : sequencer side (drives write port and read addresses)
//   slave  : RAM side (drives read data)
// Signals:
//   samp_wr_en/addr/data : delay-line write port
//   samp_rd_addr/data    : delay-line read port
//   coef_rd_addr/data    : coefficient read port
// ---------------------------------------------------------------------------
interface fir_mac_sequencer_if #(
   parameter int unsigned NUM_TAPS = 32,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned COEF_W   = 16
);
   localparam int unsigned AW = $clog2(NUM_TAPS);

   logic              samp_wr_en;
   logic [AW-1:0]     samp_wr_addr;
   logic [DATA_W-1:0] samp_wr_data;
   logic [AW-1:0]     samp_rd_addr;
   logic [DATA_W-1:0] samp_rd_data;
   logic [AW-1:0]     coef_rd_addr;
   logic [COEF_W-1:0] coef_rd_data;

   modport master (
      output samp_wr_en, samp_wr_addr, samp_wr_data, samp_rd_addr, coef_rd_addr,
      input  samp_rd_data, coef_rd_data
   );

   modport slave (
      input  samp_wr_en, samp_wr_addr, samp_wr_data, samp_rd_addr, coef_rd_addr,
      output samp_rd_data, coef_rd_data
   );
endinterface

// File: rtl/fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer
// Sequencing controller for the FIR datapath. On each sample strobe it writes
// the new sample into a circular delay-line RAM, runs NUM_TAPS multiply-
// accumulates against the coefficient RAM, then emits one rounded-down,
// saturated output sample with a one-cycle valid pulse.
//
// Build option: define FIR_EXT_TICK_EN to take the strobe from sample_tick
// (gated by en) rather than the internal CLK_HZ/SAMPLE_HZ divider.
//
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   en           : run enable; low = no new sample is started
//   sample_tick  : external strobe (FIR_EXT_TICK_EN builds only)
//   sample_in    : signed input sample, captured on the strobe
//   ram          : delay-line / coefficient RAM bus (master side)
//   y_out        : filtered output sample
//   y_valid      : one-cycle pulse when y_out updates
//   busy         : high in any state other than idle
//   overrun      : sticky, a strobe arrived while busy
// ---------------------------------------------------------------------------
module fir_mac_sequencer #(
   parameter int unsigned CLK_HZ    = 12_000_000,
   parameter int unsigned SAMPLE_HZ = 48_000,
   parameter int unsigned NUM_TAPS  = 32,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned COEF_W    = 16,
   parameter int unsigned ACC_W     = 40
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     sample_tick,
   input  logic signed [DATA_W-1:0] sample_in,
   fir_mac_sequencer_if.master      ram,
   output logic signed [DATA_W-1:0] y_out,
   output logic                     y_valid,
   output logic                     busy,
   output logic                     overrun
);
   localparam int unsigned AW     = $clog2(NUM_TAPS);
   localparam int unsigned PROD_W = DATA_W + COEF_W;

   typedef enum logic [2:0] {StIdle, StWrite, StIssue, StDrain, StDone} state_e;

   state_e                    state;
   logic                      tick;
   logic [AW-1:0]             wptr;
   logic [AW-1:0]             k;
   logic [AW-1:0]             k_nxt;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_sum;
   logic signed [ACC_W-1:0]   acc_shr;
   logic signed [DATA_W-1:0]  y_sat;

   // ------------------------------------------------------------------ strobe
`ifdef FIR_EXT_TICK_EN
   assign tick = sample_tick & en;
`else
   localparam int unsigned CLK_DIV = CLK_HZ / SAMPLE_HZ;
   localparam int unsigned CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] tick_cnt;
   logic          unused_sample_tick;

   assign unused_sample_tick = sample_tick;
   assign tick = en && (tick_cnt == CW'(CLK_DIV - 1));

   // Counter holds while en is low, so a disabled interval stretches the period.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (en) begin
         tick_cnt <= (tick_cnt == CW'(CLK_DIV - 1)) ? '0 : tick_cnt + CW'(1);
      end
   end
`endif

   // ---------------------------------------------------------------- datapath
   assign k_nxt    = k + AW'(1);
   assign prod     = $signed(ram.samp_rd_data) * $signed(ram.coef_rd_data);
   assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
   assign acc_sum  = acc + prod_ext;
   // Arithmetic shift drops the Q(COEF_W-1) fraction, rounding toward -inf.
   assign acc_shr  = acc_sum >>> (COEF_W - 1);

   // Clamp when the bits above the DATA_W sign bit are not a pure sign extension.
   always_comb begin
      y_sat = acc_shr[DATA_W-1:0];
      if (acc_shr[ACC_W-1] && !(&acc_shr[ACC_W-2:DATA_W-1])) begin
         y_sat = {1'b1, {(DATA_W-1){1'b0}}};
      end else if (!acc_shr[ACC_W-1] && (|acc_shr[ACC_W-2:DATA_W-1])) begin
         y_sat = {1'b0, {(DATA_W-1){1'b1}}};
      end
   end

   // --------------------------------------------------------------------- fsm
   // Read addresses are registered one cycle ahead of their ISSUE slot, so the
   // RAM data for tap k arrives in the slot of tap k+1 (or DRAIN for the last).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= StIdle;
         wptr             <= '0;
         k                <= '0;
         acc              <= '0;
         ram.samp_wr_en   <= 1'b0;
         ram.samp_wr_addr <= '0;
         ram.samp_wr_data <= '0;
         ram.samp_rd_addr <= '0;
         ram.coef_rd_addr <= '0;
         y_out            <= '0;
         y_valid          <= 1'b0;
         busy             <= 1'b0;
         overrun          <= 1'b0;
      end else begin
         ram.samp_wr_en <= 1'b0;
         y_valid        <= 1'b0;
         if (tick && busy) begin
            overrun <= 1'b1;
         end
         unique case (state)
            StIdle: begin
               if (tick) begin
                  ram.samp_wr_en   <= 1'b1;
                  ram.samp_wr_addr <= wptr;
                  ram.samp_wr_data <= sample_in;
                  busy             <= 1'b1;
                  state            <= StWrite;
               end
            end
            StWrite: begin
               acc              <= '0;
               k                <= '0;
               ram.samp_rd_addr <= wptr;
               ram.coef_rd_addr <= '0;
               state            <= StIssue;
            end
            StIssue: begin
               if (k != '0) begin
                  acc <= acc_sum;
               end
               if (k == AW'(NUM_TAPS - 1)) begin
                  state <= StDrain;
               end else begin
                  k                <= k_nxt;
                  ram.samp_rd_addr <= wptr - k_nxt;
                  ram.coef_rd_addr <= k_nxt;
               end
            end
            StDrain: begin
               acc     <= acc_sum;
               y_out   <= y_sat;
               y_valid <= 1'b1;
               state   <= StDone;
            end
            StDone: begin
               wptr  <= wptr + AW'(1);
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end
endmodule
